// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scanner and its decoder.
// Segment codes are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  // Everything one displayed frame is built from; captured atomically.
  typedef struct packed {
    logic [15:0] digits;
    logic        blank_lz;
    logic [3:0]  dp_mask;
  } snap_t;

  function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] k);
    return d[{k, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// BCD to seven-segment decoder; non-decimal codes 10..15 are blanked.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-coherent snapshot,
// leading-zero blanking and per-digit decimal points.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic [15:0] digits,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame
);

  if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_div
    $error("seg7_scan: SCAN_DIV must be in 2..65535");
  end

  localparam logic [15:0] PcntLast = 16'(SCAN_DIV - 1);

  logic [15:0] pcnt_q, pcnt_d;
  logic [1:0]  idx_q, idx_d;
  snap_t       snap_q, snap_d;
  logic        frame_q, frame_d;
  logic        tick, wrap;

  always_comb begin
    tick    = on && (pcnt_q == PcntLast);
    wrap    = tick && (idx_q == 2'd3);
    pcnt_d  = pcnt_q;
    if (on) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    end
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    snap_d  = snap_q;
    if (wrap) begin
      snap_d = '{digits: digits, blank_lz: blank_lz, dp_mask: dp_mask};
    end
    frame_d = wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q  <= 16'd0;
      idx_q   <= 2'd0;
      snap_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
    end
  end

  // Output decode sees only registered idx and snapshot; `on` merely gates.
  logic [3:0] cur_bcd;
  logic [6:0] dec_seg;
  logic [3:0] zero;
  logic [3:0] lz_run;
  logic       lz_blank;

  assign cur_bcd = nibble(snap_q.digits, idx_q);

  seg7_dec u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  // lz_run[k]: digits k..3 are all zero.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero[k] = (snap_q.digits[4*k +: 4] == 4'd0);
    end
    lz_run[3] = zero[3];
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lz_run[k] = lz_run[k+1] & zero[k];
    end
    lz_blank = snap_q.blank_lz && (idx_q != 2'd0) && lz_run[idx_q];
  end

  always_comb begin
    an    = 4'b1111;
    seg   = SEG_BLANK;
    dp    = 1'b0;
    frame = 1'b0;
    if (on) begin
      an    = ~(4'b0001 << idx_q);
      seg   = lz_blank ? SEG_BLANK : dec_seg;
      dp    = snap_q.dp_mask[idx_q];
      frame = frame_q;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=4 (four cycles per digit slot).
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        on;
  logic [15:0] digits;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .on       (on),
    .digits   (digits),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .frame    (frame)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until the next frame pulse (at least one cycle), bounded.
  task automatic sync_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = frame;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sync_frame: frame=%b, required 1 within 40 cycles", frame);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; on = 1'b0; digits = 16'h1234; blank_lz = 1'b0; dp_mask = 4'b0000;
    #3;
    checks++;
    if ({an, seg, dp, frame} !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_off: an=%b seg=%h dp=%b frame=%b, required 1111/00/0/0",
               an, seg, dp, frame);
    end
    on = 1'b1;
    #1;
    checks++;
    if ({an, seg, dp, frame} !== {4'b1110, 7'h3F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_on: an=%b seg=%h dp=%b frame=%b, required 1110/3f/0/0",
               an, seg, dp, frame);
    end
    step();
    step();
    checks++;
    if ({an, seg, frame} !== {4'b1110, 7'h3F, 1'b0}) begin
      errors++;
      $display("FAIL reset_held: an=%b seg=%h frame=%b, required 1110/3f/0", an, seg, frame);
    end
    rst = 1'b1;
  endtask

  // Called right after reset release: first frame shows zeros, second shows 1234.
  task automatic test_first_frames();
    logic [27:0] t1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    int          k;
    for (int s = 0; s < 32; s++) begin
      if (s != 0) step();
      k       = (s / 4) % 4;
      exp_an  = ~(4'b0001 << k);
      exp_seg = (s < 16) ? 7'h3F : t1234[7*k +: 7];
      checks++;
      if ({an, seg, frame} !== {exp_an, exp_seg, (s == 16)}) begin
        errors++;
        $display("FAIL first_frames s=%0d: an=%b seg=%h frame=%b, required %b/%h/%b",
                 s, an, seg, frame, exp_an, exp_seg, (s == 16));
      end
    end
  endtask

  task automatic test_snapshot_hold();
    logic [27:0] t1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    logic [27:0] t5678 = {7'h6D, 7'h7D, 7'h07, 7'h7F};
    logic [6:0]  exp_seg;
    sync_frame();
    for (int s = 0; s < 16; s++) begin
      if (s != 0) step();
      exp_seg = t1234[7*(s/4) +: 7];
      checks++;
      if (seg !== exp_seg) begin
        errors++;
        $display("FAIL snapshot_old s=%0d: seg=%h, required %h", s, seg, exp_seg);
      end
      if (s == 4) digits = 16'h5678;
    end
    sync_frame();
    for (int s = 0; s < 16; s++) begin
      if (s != 0) step();
      exp_seg = t5678[7*(s/4) +: 7];
      checks++;
      if (seg !== exp_seg) begin
        errors++;
        $display("FAIL snapshot_new s=%0d: seg=%h, required %h", s, seg, exp_seg);
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vd [4] = '{16'h0007, 16'h0000, 16'h9050, 16'h00AF};
    logic        vb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  vm [4] = '{4'b1000, 4'b0000, 4'b0010, 4'b0000};
    logic [27:0] ve [4] = '{{7'h00, 7'h00, 7'h00, 7'h07},
                            {7'h00, 7'h00, 7'h00, 7'h3F},
                            {7'h6F, 7'h3F, 7'h6D, 7'h3F},
                            {7'h3F, 7'h3F, 7'h00, 7'h00}};
    logic [6:0]  exp_seg;
    logic        exp_dp;
    int          k;
    for (int c = 0; c < 4; c++) begin
      digits = vd[c]; blank_lz = vb[c]; dp_mask = vm[c];
      sync_frame();
      for (int s = 0; s < 16; s++) begin
        if (s != 0) step();
        k       = s / 4;
        exp_seg = ve[c][7*k +: 7];
        exp_dp  = vm[c][k];
        checks++;
        if ({seg, dp} !== {exp_seg, exp_dp}) begin
          errors++;
          $display("FAIL blanking case=%0d s=%0d: seg=%h dp=%b, required %h/%b",
                   c, s, seg, dp, exp_seg, exp_dp);
        end
      end
    end
  endtask

  task automatic test_on_drop();
    logic [3:0] exp_an;
    digits = 16'h1234; blank_lz = 1'b0; dp_mask = 4'b1111;
    sync_frame();
    repeat (9) step();
    checks++;
    if ({an, seg, dp} !== {4'b1011, 7'h5B, 1'b1}) begin
      errors++;
      $display("FAIL drop_before: an=%b seg=%h dp=%b, required 1011/5b/1", an, seg, dp);
    end
    on = 1'b0;
    #1;
    for (int i = 0; i <= 10; i++) begin
      if (i != 0) step();
      checks++;
      if ({an, seg, dp, frame} !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL drop_off i=%0d: an=%b seg=%h dp=%b frame=%b, required 1111/00/0/0",
                 i, an, seg, dp, frame);
      end
    end
    on = 1'b1;
    #1;
    checks++;
    if ({an, seg} !== {4'b1011, 7'h5B}) begin
      errors++;
      $display("FAIL drop_resume: an=%b seg=%h, required 1011/5b", an, seg);
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_an = (i < 3) ? 4'b1011 : (i < 7) ? 4'b0111 : 4'b1110;
      checks++;
      if ({an, frame} !== {exp_an, (i == 7)}) begin
        errors++;
        $display("FAIL drop_after i=%0d: an=%b frame=%b, required %b/%b",
                 i, an, frame, exp_an, (i == 7));
      end
    end
  endtask

  // Entered at the frame-pulse sample left by test_on_drop.
  task automatic test_async_reset();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    repeat (12) step();
    checks++;
    if ({an, seg, dp} !== {4'b0111, 7'h06, 1'b1}) begin
      errors++;
      $display("FAIL areset_before: an=%b seg=%h dp=%b, required 0111/06/1", an, seg, dp);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame} !== {4'b1110, 7'h3F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL areset_now: an=%b seg=%h dp=%b frame=%b, required 1110/3f/0/0",
               an, seg, dp, frame);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({an, seg, frame} !== {4'b1110, 7'h3F, 1'b0}) begin
        errors++;
        $display("FAIL areset_held i=%0d: an=%b seg=%h frame=%b, required 1110/3f/0",
                 i, an, seg, frame);
      end
    end
    on = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame} !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL areset_off: an=%b seg=%h dp=%b frame=%b, required 1111/00/0/0",
               an, seg, dp, frame);
    end
    on  = 1'b1;
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      exp_an  = ~(4'b0001 << ((i / 4) % 4));
      exp_seg = (i == 16) ? 7'h66 : 7'h3F;
      checks++;
      if ({an, seg, frame} !== {exp_an, exp_seg, (i == 16)}) begin
        errors++;
        $display("FAIL areset_release i=%0d: an=%b seg=%h frame=%b, required %b/%h/%b",
                 i, an, seg, frame, exp_an, exp_seg, (i == 16));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_snapshot_hold();
    test_blanking();
    test_on_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
